// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg
//   Shared definitions for the pipeline hazard controller:
//   controller state encodings, operand forward-select codes and the
//   default widths/limits used as parameter defaults.
//   Optional feature macro: HAZARD_FWD_EN (see pipe_hazard_ctrl.sv).
package pipe_hazard_ctrl_pkg;

  // Register-file address bus width (legacy name Rreg_AddrBus).
  localparam int REG_ADDR_BUS_W  = 5;
  localparam int REG_AW_DEF      = REG_ADDR_BUS_W;
  localparam int MEM_TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LD_STALL = 2'd1,
    MEM_WAIT = 2'd2
  } hz_state_t;

  // ALU operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

endpackage

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
// fwd_sel
//   Match logic and forward priority for one ALU source operand.
//   Ports:
//     src_addr/src_use        source register of the ID instruction, used flag
//     ex_/mem_/wb_ wr, addr   write-enable and destination of each stage
//     stall_match             hazard that must stall ID:
//                               HAZARD_FWD_EN defined : match with EX only
//                               (top qualifies it as load-use)
//                               otherwise             : match with EX, MEM or WB
//     sel                     operand source (FWD_RF/FWD_MEM/FWD_WB),
//                             always FWD_RF when HAZARD_FWD_EN is undefined
module fwd_sel import pipe_hazard_ctrl_pkg::*; #(
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              src_use,
  input  logic              ex_wr,
  input  logic [REG_AW-1:0] ex_addr,
  input  logic              mem_wr,
  input  logic [REG_AW-1:0] mem_addr,
  input  logic              wb_wr,
  input  logic [REG_AW-1:0] wb_addr,
  output logic              stall_match,
  output logic [1:0]        sel
);

  logic live, ex_hit, mem_hit, wb_hit;

  // r0 is hardwired zero, so it never carries a dependency
  assign live    = src_use & (src_addr != '0);
  assign ex_hit  = live & ex_wr  & (src_addr == ex_addr);
  assign mem_hit = live & mem_wr & (src_addr == mem_addr);
  assign wb_hit  = live & wb_wr  & (src_addr == wb_addr);

  always_comb begin
    sel = FWD_RF;
`ifdef HAZARD_FWD_EN
    // MEM holds the younger value, so it beats WB
    if (mem_hit)     sel = FWD_MEM;
    else if (wb_hit) sel = FWD_WB;
    stall_match = ex_hit;
`else
    stall_match = ex_hit | mem_hit | wb_hit;
`endif
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
//   Hazard and sequencing controller for the 5-stage pipeline.
//   Drives hold/bubble/flush of the pipeline registers, the ALU forward
//   selects and the data-memory req/ack handshake of the MEM stage.
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     id_*                         ID source registers and use flags
//     ex_*, mem_*, wb_*            controls/destinations of later stages
//     branch_taken_ex              branch resolved taken in EX
//     dmem_ack                     data memory completed the access
//     stall_if/flush_id/hold_ex/bubble_ex/hold_mem/bubble_wb
//                                  pipeline register controls
//     fwd_a/fwd_b                  operand sources (rs/rt)
//     dmem_req, mem_err            memory request, timeout pulse
//   Macro HAZARD_FWD_EN: when defined, operands are forwarded and only a
//   load-use dependency stalls (one LD_STALL cycle); when undefined the
//   forward selects are 00 and any dependency on EX/MEM/WB stalls ID.
module pipe_hazard_ctrl import pipe_hazard_ctrl_pkg::*; #(
  parameter int REG_AW      = REG_AW_DEF,
  parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs_addr,
  input  logic [REG_AW-1:0] id_rt_addr,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic              ex_read_mem,
  input  logic              ex_wite_reg,
  input  logic [REG_AW-1:0] ex_wite_reg_addr,
  input  logic              mem_read_mem,
  input  logic              mem_wite_mem,
  input  logic              mem_wite_reg,
  input  logic [REG_AW-1:0] mem_wite_reg_addr,
  input  logic              wb_wite_reg,
  input  logic [REG_AW-1:0] wb_wite_reg_addr,
  input  logic              branch_taken_ex,
  input  logic              dmem_ack,
  output logic              stall_if,
  output logic              flush_id,
  output logic              hold_ex,
  output logic              bubble_ex,
  output logic              hold_mem,
  output logic              bubble_wb,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              dmem_req,
  output logic              mem_err
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_t              state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  // operand 0 = rs, operand 1 = rt
  logic [1:0][REG_AW-1:0] src_addr;
  logic [1:0]             src_use;
  logic [1:0]             stall_match;
  logic [1:0][1:0]        sel;

  logic mem_access, waiting, timeout, freeze, load_use, data_stall;

  assign src_addr = {id_rt_addr, id_rs_addr};
  assign src_use  = {id_use_rt, id_use_rs};

  for (genvar g = 0; g < 2; g++) begin : g_opnd
    fwd_sel #(.REG_AW(REG_AW)) u_fwd (
      .src_addr   (src_addr[g]),
      .src_use    (src_use[g]),
      .ex_wr      (ex_wite_reg),
      .ex_addr    (ex_wite_reg_addr),
      .mem_wr     (mem_wite_reg),
      .mem_addr   (mem_wite_reg_addr),
      .wb_wr      (wb_wite_reg),
      .wb_addr    (wb_wite_reg_addr),
      .stall_match(stall_match[g]),
      .sel        (sel[g])
    );
  end

  assign mem_access = mem_read_mem | mem_wite_mem;
  assign waiting    = (state_q == MEM_WAIT);
  // cnt_q counts freeze cycles already spent; the first one happens in RUN
  // before MEM_WAIT is entered, so hitting MEM_TIMEOUT here caps the freeze.
  assign timeout    = waiting & ~dmem_ack & (cnt_q == CNT_W'(MEM_TIMEOUT));
  // Freeze starts in the first request cycle without ack; ack releases in
  // that same cycle.
  assign freeze     = (waiting | mem_access) & ~dmem_ack & ~timeout;

`ifdef HAZARD_FWD_EN
  // In LD_STALL the load has already moved to MEM; the bubble is in EX.
  assign load_use   = (state_q != LD_STALL) & ex_read_mem & (|stall_match);
  assign data_stall = load_use;
`else
  logic unused_ex_read_mem;
  assign unused_ex_read_mem = ex_read_mem;
  assign load_use   = 1'b0;
  assign data_stall = |stall_match;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // next state
  always_comb begin
    state_d = RUN;
    cnt_d   = '0;
    if (freeze) begin
      state_d = MEM_WAIT;
      cnt_d   = waiting ? cnt_q + 1'b1 : CNT_W'(1);
    end else if (load_use && !branch_taken_ex) begin
      state_d = LD_STALL;
    end
  end

  // outputs: freeze beats branch flush, flush beats data stall
  always_comb begin
    stall_if  = 1'b0;
    flush_id  = 1'b0;
    hold_ex   = 1'b0;
    bubble_ex = 1'b0;
    hold_mem  = 1'b0;
    bubble_wb = 1'b0;
    fwd_a     = FWD_RF;
    fwd_b     = FWD_RF;
    dmem_req  = 1'b0;
    mem_err   = 1'b0;
    if (!rst) begin
      fwd_a    = sel[0];
      fwd_b    = sel[1];
      dmem_req = waiting | mem_access;
      mem_err  = timeout;
      if (freeze) begin
        stall_if  = 1'b1;
        hold_ex   = 1'b1;
        hold_mem  = 1'b1;
        bubble_wb = 1'b1;
      end else if (branch_taken_ex) begin
        flush_id  = 1'b1;
        bubble_ex = 1'b1;
      end else if (data_stall) begin
        stall_if  = 1'b1;
        bubble_ex = 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl
//   Table-driven single-cycle vectors, hand-written multi-cycle sequences
//   and randomized stimulus, all compared against a behavioural model.
//   Honours HAZARD_FWD_EN in the same way as the design.
module tb_pipe_hazard_ctrl;

  localparam int TMO = 15;

  // output bundle bit positions
  localparam int O_STALL = 11, O_FLUSH = 10, O_HEX = 9, O_BEX = 8,
                 O_HMEM = 7, O_BWB = 6, O_REQ = 1, O_ERR = 0;

  typedef struct packed {
    logic       rst;
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic       exrd, exwr;
    logic [4:0] exa;
    logic       memrd, memwm, memwr;
    logic [4:0] mema;
    logic       wbwr;
    logic [4:0] wba;
    logic       br, ack;
  } in_t;

  typedef struct {
    logic [4:0] rs, rt;
    logic       urs, urt, exrd, exwr;
    logic [4:0] exa;
    logic       memwr;
    logic [4:0] mema;
    logic       wbwr;
    logic [4:0] wba;
    logic       br;
    logic [1:0] fa, fb;   // forwarding build
    logic       st_f;     // raw dependency stall, forwarding build
    logic       st_n;     // raw dependency stall, no-forwarding build
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [4:0] id_rs_addr, id_rt_addr, ex_wite_reg_addr, mem_wite_reg_addr, wb_wite_reg_addr;
  logic       id_use_rs, id_use_rt, ex_read_mem, ex_wite_reg;
  logic       mem_read_mem, mem_wite_mem, mem_wite_reg, wb_wite_reg;
  logic       branch_taken_ex, dmem_ack;
  logic       stall_if, flush_id, hold_ex, bubble_ex, hold_mem, bubble_wb;
  logic [1:0] fwd_a, fwd_b;
  logic       dmem_req, mem_err;

  int n_chk = 0;
  int n_fail = 0;

  // model state: an access outstanding from an earlier cycle, how many
  // freeze cycles it has cost, and whether last cycle inserted the
  // load-use bubble
  bit   m_busy = 0;
  int   m_waited = 0;
  bit   m_ld = 0;
  logic [11:0] last;

  pipe_hazard_ctrl dut (
    .clk(clk), .rst(rst),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .ex_read_mem(ex_read_mem), .ex_wite_reg(ex_wite_reg),
    .ex_wite_reg_addr(ex_wite_reg_addr),
    .mem_read_mem(mem_read_mem), .mem_wite_mem(mem_wite_mem),
    .mem_wite_reg(mem_wite_reg), .mem_wite_reg_addr(mem_wite_reg_addr),
    .wb_wite_reg(wb_wite_reg), .wb_wite_reg_addr(wb_wite_reg_addr),
    .branch_taken_ex(branch_taken_ex), .dmem_ack(dmem_ack),
    .stall_if(stall_if), .flush_id(flush_id), .hold_ex(hold_ex),
    .bubble_ex(bubble_ex), .hold_mem(hold_mem), .bubble_wb(bubble_wb),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .dmem_req(dmem_req), .mem_err(mem_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", nm, act, exp);
    end
  endtask

  function automatic bit dep(logic [4:0] src, logic u, logic wr, logic [4:0] dst);
    return u && src != 0 && wr && src == dst;
  endfunction

  // Expected outputs from the controller rules, plus the model's next state.
  task automatic model(input in_t v, output logic [11:0] e,
                       output bit busy_n, output int waited_n, output bit ld_n);
    bit acc, tmo, frz, sa, sb;
    logic [1:0] fa, fb;
    logic st, fl, hx, bx, hm, bw;
    e = '0; busy_n = 0; waited_n = 0; ld_n = 0;
    if (v.rst) return;
    acc = m_busy || v.memrd || v.memwm;
    tmo = m_busy && !v.ack && m_waited == TMO;
    frz = acc && !v.ack && !tmo;
    fa = 0; fb = 0; st = 0; fl = 0; hx = 0; bx = 0; hm = 0; bw = 0;
`ifdef HAZARD_FWD_EN
    fa = dep(v.rs, v.urs, v.memwr, v.mema) ? 2'b01 : dep(v.rs, v.urs, v.wbwr, v.wba) ? 2'b10 : 2'b00;
    fb = dep(v.rt, v.urt, v.memwr, v.mema) ? 2'b01 : dep(v.rt, v.urt, v.wbwr, v.wba) ? 2'b10 : 2'b00;
    sa = dep(v.rs, v.urs, v.exwr & v.exrd, v.exa);
    sb = dep(v.rt, v.urt, v.exwr & v.exrd, v.exa);
    if (m_ld) begin sa = 0; sb = 0; end
`else
    sa = dep(v.rs, v.urs, v.exwr, v.exa) || dep(v.rs, v.urs, v.memwr, v.mema) || dep(v.rs, v.urs, v.wbwr, v.wba);
    sb = dep(v.rt, v.urt, v.exwr, v.exa) || dep(v.rt, v.urt, v.memwr, v.mema) || dep(v.rt, v.urt, v.wbwr, v.wba);
`endif
    if (frz) begin
      st = 1; hx = 1; hm = 1; bw = 1;
    end else if (v.br) begin
      fl = 1; bx = 1;
    end else if (sa || sb) begin
      st = 1; bx = 1;
`ifdef HAZARD_FWD_EN
      ld_n = 1;
`endif
    end
    busy_n   = frz;
    waited_n = frz ? m_waited + 1 : 0;
    e = {st, fl, hx, bx, hm, bw, fa, fb, acc, tmo};
  endtask

  // Apply one cycle of inputs, compare against the model mid-cycle, clock.
  task automatic step(input in_t v, input string nm);
    logic [11:0] e;
    bit bn; int wn; bit ln;
    rst = v.rst; id_rs_addr = v.rs; id_rt_addr = v.rt;
    id_use_rs = v.urs; id_use_rt = v.urt;
    ex_read_mem = v.exrd; ex_wite_reg = v.exwr; ex_wite_reg_addr = v.exa;
    mem_read_mem = v.memrd; mem_wite_mem = v.memwm; mem_wite_reg = v.memwr;
    mem_wite_reg_addr = v.mema; wb_wite_reg = v.wbwr; wb_wite_reg_addr = v.wba;
    branch_taken_ex = v.br; dmem_ack = v.ack;
    #2;
    model(v, e, bn, wn, ln);
    last = {stall_if, flush_id, hold_ex, bubble_ex, hold_mem, bubble_wb,
            fwd_a, fwd_b, dmem_req, mem_err};
    chk({"model ", nm}, int'(last), int'(e));
    @(posedge clk); #1;
    m_busy = bn; m_waited = wn; m_ld = ln;
  endtask

  task automatic do_reset();
    in_t r;
    r = '0; r.rst = 1;
    step(r, "reset");
  endtask

  vec_t vt[10];

  initial begin
    in_t v;
    int e_fa, e_fb, e_st;
    @(posedge clk); #1;

    // reset state
    do_reset();
    chk("reset outputs", int'(last), 0);

    //           rs rt urs urt exrd exwr exa memwr mema wbwr wba br  fa    fb   stf stn
    vt[0] = '{5'd1, 5'd2, 1, 1, 1, 1, 5'd7, 1, 5'd8, 1, 5'd9, 0, 2'b00, 2'b00, 0, 0};
    vt[1] = '{5'd1, 5'd5, 1, 1, 0, 0, 5'd0, 1, 5'd5, 1, 5'd5, 0, 2'b00, 2'b01, 0, 1};
    vt[2] = '{5'd1, 5'd0, 1, 1, 0, 0, 5'd0, 1, 5'd0, 1, 5'd0, 0, 2'b00, 2'b00, 0, 0};
    vt[3] = '{5'd4, 5'd2, 1, 1, 0, 0, 5'd0, 0, 5'd4, 1, 5'd4, 0, 2'b10, 2'b00, 0, 1};
    vt[4] = '{5'd6, 5'd2, 0, 1, 0, 0, 5'd0, 1, 5'd6, 0, 5'd0, 0, 2'b00, 2'b00, 0, 0};
    vt[5] = '{5'd3, 5'd2, 1, 1, 1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 2'b00, 2'b00, 1, 1};
    vt[6] = '{5'd3, 5'd2, 1, 1, 0, 1, 5'd3, 0, 5'd0, 0, 5'd0, 0, 2'b00, 2'b00, 0, 1};
    vt[7] = '{5'd3, 5'd2, 1, 1, 1, 1, 5'd3, 0, 5'd0, 0, 5'd0, 1, 2'b00, 2'b00, 1, 1};
    vt[8] = '{5'd3, 5'd2, 1, 1, 1, 0, 5'd3, 0, 5'd0, 0, 5'd0, 0, 2'b00, 2'b00, 0, 0};
    vt[9] = '{5'd9, 5'd9, 1, 1, 0, 0, 5'd0, 1, 5'd9, 1, 5'd9, 0, 2'b01, 2'b01, 0, 1};

    foreach (vt[i]) begin
      do_reset();
      v = '0;
      v.rs = vt[i].rs; v.rt = vt[i].rt; v.urs = vt[i].urs; v.urt = vt[i].urt;
      v.exrd = vt[i].exrd; v.exwr = vt[i].exwr; v.exa = vt[i].exa;
      v.memwr = vt[i].memwr; v.mema = vt[i].mema;
      v.wbwr = vt[i].wbwr; v.wba = vt[i].wba; v.br = vt[i].br;
`ifdef HAZARD_FWD_EN
      e_fa = vt[i].fa; e_fb = vt[i].fb; e_st = vt[i].st_f;
`else
      e_fa = 0; e_fb = 0; e_st = vt[i].st_n;
`endif
      step(v, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d stall/flush/bubble/fwd", i),
          int'({last[O_STALL], last[O_FLUSH], last[O_BEX], last[5:4], last[3:2]}),
          int'({e_st[0] & ~vt[i].br, vt[i].br, e_st[0] | vt[i].br, e_fa[1:0], e_fb[1:0]}));
    end

    // load-use: one bubble, then the load forwards from WB
    do_reset();
    v = '0; v.rs = 3; v.urs = 1; v.exrd = 1; v.exwr = 1; v.exa = 3;
    step(v, "ldu c0");
    chk("ldu c0 stall_if+bubble_ex", int'({last[O_STALL], last[O_BEX]}), 3);
    v = '0; v.rs = 3; v.urs = 1; v.wbwr = 1; v.wba = 3;
    step(v, "ldu c1");
`ifdef HAZARD_FWD_EN
    chk("ldu c1 stall_if/bubble_ex/fwd_a", int'({last[O_STALL], last[O_BEX], last[5:4]}), 2);
`else
    chk("ldu c1 stall_if/bubble_ex/fwd_a", int'({last[O_STALL], last[O_BEX], last[5:4]}), 12);
`endif

    // memory wait: ack three cycles after the request
    do_reset();
    v = '0; v.memrd = 1;
    for (int c = 0; c < 3; c++) begin
      step(v, $sformatf("mwait c%0d", c));
      chk($sformatf("mwait c%0d hold_mem/bubble_wb/req", c),
          int'({last[O_HMEM], last[O_BWB], last[O_REQ]}), 7);
    end
    v.ack = 1;
    step(v, "mwait ack");
    chk("mwait ack release", int'({last[O_STALL], last[O_HMEM], last[O_BWB], last[O_REQ]}), 1);
    v = '0;
    step(v, "mwait after");
    chk("mwait after idle", int'(last), 0);

    // timeout: ack never comes
    do_reset();
    v = '0; v.memrd = 1;
    for (int c = 0; c < TMO; c++) begin
      step(v, $sformatf("tmo c%0d", c));
      if (last[O_HMEM] !== 1'b1 || last[O_ERR] !== 1'b0)
        chk($sformatf("tmo c%0d hold_mem/mem_err", c), int'({last[O_HMEM], last[O_ERR]}), 2);
    end
    step(v, "tmo expire");
    chk("tmo expire mem_err/release", int'({last[O_ERR], last[O_HMEM], last[O_STALL]}), 4);
    v = '0;
    step(v, "tmo after");
    chk("tmo after err cleared", int'({last[O_ERR], last[O_HMEM]}), 0);

    // taken branch during MEM_WAIT: flush deferred to the ack cycle
    do_reset();
    v = '0; v.memrd = 1; v.br = 1;
    step(v, "brw c0");
    chk("brw c0 flush held off", int'({last[O_FLUSH], last[O_HMEM]}), 1);
    step(v, "brw c1");
    chk("brw c1 flush held off", int'({last[O_FLUSH], last[O_HMEM]}), 1);
    v.ack = 1;
    step(v, "brw ack");
    chk("brw ack flush/bubble_ex", int'({last[O_FLUSH], last[O_BEX], last[O_HMEM]}), 6);

    // reset in the middle of a wait: abandoned, no mem_err
    do_reset();
    v = '0; v.memrd = 1;
    for (int c = 0; c < 3; c++) step(v, $sformatf("rstw c%0d", c));
    v.rst = 1;
    step(v, "rstw rst");
    chk("rstw during reset", int'(last), 0);
    v = '0;
    step(v, "rstw after");
    chk("rstw after all zero", int'(last), 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      v = '0;
      v.rst   = ($urandom_range(0, 63) == 0);
      v.rs    = 5'($urandom_range(0, 7));
      v.rt    = 5'($urandom_range(0, 7));
      v.urs   = 1'($urandom_range(0, 1));
      v.urt   = 1'($urandom_range(0, 1));
      v.exrd  = 1'($urandom_range(0, 1));
      v.exwr  = 1'($urandom_range(0, 1));
      v.exa   = 5'($urandom_range(0, 7));
      v.memrd = ($urandom_range(0, 5) == 0);
      v.memwm = ($urandom_range(0, 5) == 0);
      v.memwr = 1'($urandom_range(0, 1));
      v.mema  = 5'($urandom_range(0, 7));
      v.wbwr  = 1'($urandom_range(0, 1));
      v.wba   = 5'($urandom_range(0, 7));
      v.br    = ($urandom_range(0, 7) == 0);
      v.ack   = ($urandom_range(0, (i < 1500) ? 2 : 12) == 0);
      step(v, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and sequencing controller for the five-stage pipeline. It drives the hold, bubble and flush controls of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, selects the ALU operand forwarding sources, and runs the data-memory request/acknowledge handshake for the MEM stage. It sits beside the pipeline registers and decides, every cycle, whether each stage advances, holds, or is replaced by a bubble.

## Interface
- REG_AW, 5, register address width; equals the `Rreg_AddrBus` width
- MEM_TIMEOUT, 15, maximum wait cycles for `dmem_ack` before the access is abandoned
- clk  in  1  pipeline clock
- rst  in  1  synchronous, active-high reset
- id_rs_addr, id_rt_addr  in  REG_AW  source registers of the instruction in ID
- id_use_rs, id_use_rt  in  1  the ID instruction actually reads rs / rt
- ex_read_mem, ex_wite_reg  in  1  controls of the instruction in EX
- ex_wite_reg_addr  in  REG_AW  destination register of the EX instruction
- mem_read_mem, mem_wite_mem, mem_wite_reg  in  1  controls of the instruction in MEM
- mem_wite_reg_addr  in  REG_AW  destination register of the MEM instruction
- wb_wite_reg  in  1  the WB instruction writes the register file
- wb_wite_reg_addr  in  REG_AW  destination register of the WB instruction
- branch_taken_ex  in  1  branch resolved taken in EX
- dmem_ack  in  1  data memory has completed the current access
- stall_if  out  1  hold PC and IF/ID
- flush_id  out  1  load a NOP into IF/ID
- hold_ex  out  1  hold ID/EX
- bubble_ex  out  1  load a NOP into ID/EX
- hold_mem  out  1  hold EX/MEM
- bubble_wb  out  1  load a NOP into MEM/WB
- fwd_a, fwd_b  out  2  operand source: 00 register file, 01 MEM-stage ALU result, 10 WB-stage result
- dmem_req  out  1  data-memory access request
- mem_err  out  1  one-cycle pulse when an access times out

## Operation
- States: RUN, LD_STALL, MEM_WAIT.
- Hazard matches:
  - A match is a nonzero source register that is used and equals a writing stage's destination.
  - Register 0 never matches.
- Forwarding:
  - fwd_x = 01 on a match with MEM.
  - Otherwise fwd_x = 10 on a match with WB.
  - Otherwise fwd_x = 00. MEM has priority over WB.
- Load-use:
  - Condition: in RUN, `ex_read_mem & ex_wite_reg` and a match with EX.
  - Action: stall_if=1, bubble_ex=1, and move to LD_STALL.
  - LD_STALL lasts exactly 1 cycle and releases the stall. The load then forwards from WB.
- Memory access:
  - When MEM holds `mem_read_mem | mem_wite_mem`, dmem_req=1.
  - If `dmem_ack` is low, move to MEM_WAIT.
  - In MEM_WAIT, stall_if, hold_ex and hold_mem are 1 and bubble_wb is 1. dmem_req stays high until ack.
  - On `dmem_ack`, release in that same cycle and return to RUN.
- Timeout:
  - A wait counter counts MEM_WAIT cycles.
  - When it reaches MEM_TIMEOUT without ack: mem_err=1 for one cycle, release, return to RUN, and clear the counter.
- Branch:
  - `branch_taken_ex` asserts flush_id=1 and bubble_ex=1 for that cycle.
  - Branch versus load-use in the same cycle: the flush wins, with no LD_STALL entry.
- MEM_WAIT freeze overrides flush. The branch stays in EX and is re-evaluated on release.
- Reset:
  - While rst=1, every output is 0, the state is RUN and the counter is 0.
  - A pending wait is abandoned with no mem_err.

## Timing
- Forward, stall, flush and bubble outputs are combinational from the current state and inputs: same-cycle.
- State and counter update on the rising clk edge.
- Memory access latency:
  - Zero-wait access (ack in the first request cycle) costs 0 freeze cycles.
  - Ack after n cycles costs n freeze cycles.
  - Freeze is capped at MEM_TIMEOUT cycles.
- Load-use costs exactly 1 bubble cycle.
- A taken branch costs 2 squashed instructions.

## Configuration
- HAZARD_FWD_EN defined:
  - Forwarding is active as described above.
- HAZARD_FWD_EN not defined:
  - fwd_a and fwd_b are tied to 00.
  - Any match with EX, MEM or WB stalls: stall_if=1 and bubble_ex=1 until the matches clear, at most 3 cycles.
  - The load-use path reuses this stall, so LD_STALL is not entered.

## Structure
- def.v holds:
  - the state encodings RUN/LD_STALL/MEM_WAIT
  - the forward-select codes FWD_RF/FWD_MEM/FWD_WB
  - the REG_AW default, tied to `Rreg_AddrBus`
- One combinational sub-module, `fwd_sel`, does the match logic and priority for one source operand. It is instantiated twice, for rs and rt.

## Test plan
- Load-use:
  - Stimulus: EX ld writes r3; ID uses rs=r3.
  - Required: 1 cycle with stall_if=1 and bubble_ex=1; the next cycle fwd_a=10.
- Forwarding priority:
  - Stimulus: MEM and WB both write r5; ID rt=r5.
  - Required: fwd_b=01. With r0 instead of r5, fwd_b=00.
- Memory wait:
  - Stimulus: mem_read_mem=1 with dmem_ack arriving 3 cycles later.
  - Required: hold_mem=1 and bubble_wb=1 for 3 cycles, dmem_req high throughout, release on ack.
- Timeout:
  - Stimulus: dmem_ack stuck low.
  - Required: mem_err pulses after 15 cycles and the pipeline releases.
- Branch:
  - Stimulus: branch_taken_ex together with a load-use condition.
  - Required: flush_id=1 and bubble_ex=1, no LD_STALL.
  - Stimulus: the same branch during MEM_WAIT.
  - Required: the flush is deferred until ack.
- Reset:
  - Stimulus: rst asserted mid-MEM_WAIT.
  - Required: the next cycle has all outputs 0, state RUN, no mem_err.
